// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous requests.
module dmem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic [1:0]    we0_i,
  input  logic [1:0]    we1_i,
  input  logic [2:0]    re0_i,
  input  logic [2:0]    re1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [31:0]   wd0_i,
  input  logic [31:0]   wd1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [31:0]   rdata_o,
  output logic          err_o,
  output logic          busy_o,
  output logic [AW-1:0] mem_a_o,
  output logic [31:0]   mem_wd_o,
  output logic [1:0]    mem_we_o,
  output logic [2:0]    mem_re_o,
  input  logic [31:0]   mem_rd_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [1:0]    we_q, we_d;
  logic [2:0]    re_q, re_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          any_req;
  logic          winner;
  logic          in_range;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic          last_owner_q, last_owner_d;
`endif

  assign any_req  = req0_i | req1_i;
  assign in_range = (addr_q < DEPTH_A);

  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    winner = ~req0_i;
`else
    // On a tie, the requester not served last time wins.
    winner = (req0_i && req1_i) ? ~last_owner_q : req1_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    re_d    = re_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE, S_RESP: begin
        if (any_req) begin
          state_d = S_ACCESS;
          owner_d = winner;
          we_d    = winner ? we1_i   : we0_i;
          re_d    = winner ? re1_i   : re0_i;
          addr_d  = winner ? addr1_i : addr0_i;
          wd_d    = winner ? wd1_i   : wd0_i;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_owner_d = winner;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        rdata_d = in_range ? mem_rd_i : 32'd0;
        err_d   = ~in_range;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 2'b00;
      re_q    <= 3'b000;
      addr_q  <= '0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Memory bus is decoded from state so an async reset idles it at once.
  always_comb begin
    mem_a_o  = '0;
    mem_wd_o = 32'd0;
    mem_we_o = 2'b00;
    mem_re_o = 3'b000;
    if (state_q == S_ACCESS) begin
      mem_a_o  = addr_q;
      mem_wd_o = wd_q;
      mem_we_o = in_range ? we_q : 2'b00;
      mem_re_o = re_q;
    end
  end

  assign gnt0_o    = (state_q == S_ACCESS) && !owner_q;
  assign gnt1_o    = (state_q == S_ACCESS) &&  owner_q;
  assign rvalid0_o = (state_q == S_RESP)   && !owner_q;
  assign rvalid1_o = (state_q == S_RESP)   &&  owner_q;
  assign busy_o    = (state_q == S_ACCESS) || (state_q == S_RESP);
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus scoreboard of responses,
// with a behavioural sub-word memory model attached to the memory bus.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_i, req1_i;
  logic [1:0]  we0_i, we1_i;
  logic [2:0]  re0_i, re1_i;
  logic [31:0] addr0_i, addr1_i;
  logic [31:0] wd0_i, wd1_i;
  logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err_o, busy_o;
  logic [31:0] rdata_o, mem_a_o, mem_wd_o, mem_rd_i;
  logic [1:0]  mem_we_o;
  logic [2:0]  mem_re_o;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.DEPTH(256), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .req1_i(req1_i),
    .we0_i(we0_i), .we1_i(we1_i),
    .re0_i(re0_i), .re1_i(re1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wd0_i(wd0_i), .wd1_i(wd1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_rd_i(mem_rd_i)
  );

  always #5 clk = ~clk;

  // Memory model: combinational sub-word read, posedge sub-word write.
  logic [31:0] tb_mem [256];
  logic [31:0] mem_word;

  always_comb begin
    mem_word = tb_mem[mem_a_o[7:0]];
    case (mem_re_o)
      3'b001:  mem_rd_i = {{24{mem_word[7]}}, mem_word[7:0]};
      3'b010:  mem_rd_i = {{16{mem_word[15]}}, mem_word[15:0]};
      3'b011:  mem_rd_i = {24'd0, mem_word[7:0]};
      3'b100:  mem_rd_i = {16'd0, mem_word[15:0]};
      default: mem_rd_i = mem_word;
    endcase
  end

  always @(posedge clk) begin
    case (mem_we_o)
      2'b01:   tb_mem[mem_a_o[7:0]][7:0]  <= mem_wd_o[7:0];
      2'b10:   tb_mem[mem_a_o[7:0]][15:0] <= mem_wd_o[15:0];
      2'b11:   tb_mem[mem_a_o[7:0]]       <= mem_wd_o;
      default: ;
    endcase
  end

  typedef struct {
    logic        owner;
    logic [1:0]  we;
    logic [2:0]  re;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  exp_we;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  vec_t  vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every rvalid must match the oldest pushed expectation.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      check("one_gnt", {31'd0, gnt0_o & gnt1_o}, 32'd0);
      check("one_rvalid", {31'd0, rvalid0_o & rvalid1_o}, 32'd0);
      if (rvalid0_o || rvalid1_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {31'd0, rvalid1_o}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("resp_owner", {31'd0, rvalid1_o}, {31'd0, e.owner});
          check("resp_rdata", rdata_o, e.rdata);
          check("resp_err", {31'd0, err_o}, {31'd0, e.err});
          $display("resp owner=%0d rdata=%h err=%0d", rvalid1_o, rdata_o, err_o);
        end
      end
    end
  end

  task automatic drive(input logic owner, input logic on, input logic [1:0] we,
                       input logic [2:0] re, input logic [31:0] addr, input logic [31:0] wd);
    if (owner) begin
      req1_i = on; we1_i = we; re1_i = re; addr1_i = addr; wd1_i = wd;
    end else begin
      req0_i = on; we0_i = we; re0_i = re; addr0_i = addr; wd0_i = wd;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_o) check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    resp_t e;
    wait_idle();
    drive(v.owner, 1'b1, v.we, v.re, v.addr, v.wd);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(v.owner ? gnt1_o : gnt0_o) && n < 8);
    check("gnt_latency", n, 1);
    check("gnt_other", {31'd0, v.owner ? gnt0_o : gnt1_o}, 32'd0);
    check("mem_we", {30'd0, mem_we_o}, {30'd0, v.exp_we});
    check("mem_re", {29'd0, mem_re_o}, {29'd0, v.re});
    check("mem_a", mem_a_o, v.addr);
    check("mem_wd", mem_wd_o, v.wd);
    e.owner = v.owner; e.rdata = v.exp_rdata; e.err = v.exp_err;
    exp_q.push_back(e);
    $display("txn owner=%0d we=%b re=%b addr=%h wd=%h", v.owner, v.we, v.re, v.addr, v.wd);
    drive(v.owner, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("rvalid_latency", {31'd0, v.owner ? rvalid1_o : rvalid0_o}, 32'd1);
  endtask

  initial begin
    resp_t e;
    vec_t  v;
    logic  exp_order [4];
    int    lim0, lim1, g0, g1, k, last_cyc;

    for (int i = 0; i < 256; i++) tb_mem[i] = 32'd0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1};
    lim0 = 3; lim1 = 1;
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    lim0 = 2; lim1 = 2;
`endif

    //          own   we     re      addr          wd            exp_we exp_rdata     err
    vecs[0]  = '{1'b0, 2'b11, 3'b000, 32'd4,        32'hDEADBEEF, 2'b11, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 3'b000, 32'd4,        32'd0,        2'b00, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 3'b000, 32'd256,      32'h12345678, 2'b00, 32'h00000000, 1'b1};
    vecs[3]  = '{1'b0, 2'b00, 3'b000, 32'd0,        32'd0,        2'b00, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 2'b01, 3'b000, 32'd1,        32'h123456F0, 2'b01, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b1, 2'b00, 3'b001, 32'd1,        32'd0,        2'b00, 32'hFFFFFFF0, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 3'b011, 32'd1,        32'd0,        2'b00, 32'h000000F0, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 3'b000, 32'd2,        32'hABCD8001, 2'b10, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 2'b00, 3'b010, 32'd2,        32'd0,        2'b00, 32'hFFFF8001, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 3'b100, 32'd2,        32'd0,        2'b00, 32'h00008001, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 3'b000, 32'h00000104, 32'd0,        2'b00, 32'h00000000, 1'b1};
    vecs[11] = '{1'b1, 2'b11, 3'b000, 32'd255,      32'h55AA55AA, 2'b11, 32'h00000000, 1'b0};
    vecs[12] = '{1'b1, 2'b00, 3'b000, 32'd255,      32'd0,        2'b00, 32'h55AA55AA, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    #2;
    check("rst_gnt", {30'd0, gnt1_o, gnt0_o}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid1_o, rvalid0_o}, 32'd0);
    check("rst_err_busy", {30'd0, err_o, busy_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_mem_ctl", {27'd0, mem_we_o, mem_re_o}, 32'd0);
    check("rst_mem_a", mem_a_o, 32'd0);
    check("rst_mem_wd", mem_wd_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);
    check("word0_unchanged", tb_mem[0], 32'd0);

    // Fairness: both held; grants must alternate and be 2 cycles apart.
    wait_idle();
    drive(1'b0, 1'b1, 2'b00, 3'b000, 32'd1, 32'd0);
    drive(1'b1, 1'b1, 2'b00, 3'b000, 32'd2, 32'd0);
    g0 = 0; g1 = 0; k = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      @(posedge clk); #1;
      if (gnt0_o || gnt1_o) begin
        check("fair_order", {31'd0, gnt1_o}, {31'd0, exp_order[k]});
        if (k > 0) check("fair_spacing", cyc - last_cyc, 2);
        $display("fair grant %0d owner=%0d", k, gnt1_o);
        last_cyc = cyc;
        e.owner = gnt1_o; e.err = 1'b0;
        e.rdata = gnt1_o ? 32'h00008001 : 32'h000000F0;
        exp_q.push_back(e);
        if (gnt1_o) begin
          g1++;
          if (g1 == lim1) req1_i = 1'b0;
        end else begin
          g0++;
          if (g0 == lim0) req0_i = 1'b0;
        end
        k++;
      end
    end
    check("fair_count", k, 4);
    req0_i = 1'b0; req1_i = 1'b0;

    // Reset in the middle of a store's ACCESS cycle.
    wait_idle();
    drive(1'b0, 1'b1, 2'b11, 3'b000, 32'd8, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("abort_gnt", {31'd0, gnt0_o}, 32'd1);
    check("abort_we_pre", {30'd0, mem_we_o}, 32'd3);
    $display("txn owner=0 sw addr=8 aborted by reset");
    #2 rst = 1'b1;
    #1;
    check("abort_we_now", {30'd0, mem_we_o}, 32'd0);
    check("abort_gnt_off", {31'd0, gnt0_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = '{1'b0, 2'b00, 3'b000, 32'd8, 32'd0, 2'b00, 32'h00000000, 1'b0};
    run_vec(v);

    // req1 pulses inside requester 0's ACCESS cycle and is never sampled.
    wait_idle();
    drive(1'b0, 1'b1, 2'b00, 3'b000, 32'd4, 32'd0);
    @(posedge clk); #1;
    check("wd_gnt0", {31'd0, gnt0_o}, 32'd1);
    e.owner = 1'b0; e.rdata = 32'hDEADBEEF; e.err = 1'b0;
    exp_q.push_back(e);
    $display("txn owner=0 lw addr=4 with req1 pulse");
    req0_i = 1'b0;
    #1 drive(1'b1, 1'b1, 2'b11, 3'b000, 32'd3, 32'hFFFFFFFF);
    #3 drive(1'b1, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("wd_rvalid0", {31'd0, rvalid0_o}, 32'd1);
    check("wd_gnt1_resp", {31'd0, gnt1_o}, 32'd0);
    @(posedge clk); #1;
    check("wd_idle", {31'd0, busy_o}, 32'd0);
    check("wd_gnt1_idle", {31'd0, gnt1_o}, 32'd0);
    check("wd_mem3", tb_mem[3], 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
